// File: rtl/sram_ctrl_pkg.sv
// Shared constants and helpers for the 1rw1r SRAM macro controller.
package sram_ctrl_pkg;

  // Macro geometry defaults (32 x 512, byte-lane write enables)
  localparam int unsigned SRAM_ADDR_WIDTH   = 9;
  localparam int unsigned SRAM_DATA_WIDTH   = 32;
  localparam int unsigned SRAM_NUM_WMASKS   = 4;
  localparam int unsigned SRAM_BYTE_WIDTH   = SRAM_DATA_WIDTH / SRAM_NUM_WMASKS;
  localparam int unsigned SRAM_RSP_DEPTH    = 2;

  // Edges from request acceptance to read data landing in the response FIFO
  localparam int unsigned SRAM_READ_LATENCY = 2;

  // Field widths of one port-0 request (we + wmask + addr + wdata) and one response
  localparam int unsigned SRAM_REQ_WIDTH =
    1 + SRAM_NUM_WMASKS + SRAM_ADDR_WIDTH + SRAM_DATA_WIDTH;
  localparam int unsigned SRAM_RSP_WIDTH = SRAM_DATA_WIDTH;

  // Classification of a port-0 request in the cycle it is accepted
  typedef enum logic [1:0] {
    REQ_IDLE      = 2'd0,
    REQ_READ      = 2'd1,
    REQ_WRITE     = 2'd2,
    REQ_WRITE_NOP = 2'd3
  } req_kind_e;

  // Bits needed to hold the values 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // Bits needed to index n entries (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small circular response FIFO holding captured read data for one port.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = SRAM_RSP_DEPTH,
  parameter int unsigned WIDTH = SRAM_RSP_WIDTH,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned     PTR_W    = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Request/response front end for one 1rw1r SRAM macro: registers the macro
// pins, tracks reads in flight, captures dout and buffers responses per port.
module sram_1rw1r_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int unsigned RSP_DEPTH  = SRAM_RSP_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  // port 0: read/write requests
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [NUM_WMASKS-1:0] p0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  // port 1: read-only requests
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  // macro port 0
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  // macro port 1
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int unsigned LAT   = SRAM_READ_LATENCY;
  localparam int unsigned CNT_W = cnt_width(RSP_DEPTH);
  localparam int unsigned OCC_W = cnt_width(RSP_DEPTH + LAT);
  localparam logic [OCC_W-1:0] CREDIT_LIMIT = OCC_W'(RSP_DEPTH);

  req_kind_e        p0_kind;
  logic             p0_fire;
  logic             p0_rd_fire;
  logic             p1_fire;
  logic             p1_collision;
  logic [LAT-1:0]   p0_pipe;
  logic [LAT-1:0]   p1_pipe;
  logic [CNT_W-1:0] p0_count;
  logic [CNT_W-1:0] p1_count;
  logic [OCC_W-1:0] p0_occ;
  logic [OCC_W-1:0] p1_occ;
  logic             p0_fifo_empty;
  logic             p1_fifo_empty;

  // Occupancy = reads still travelling through the macro + responses buffered
  always_comb begin
    p0_occ = OCC_W'(p0_count);
    p1_occ = OCC_W'(p1_count);
    for (int unsigned i = 0; i < LAT; i++) begin
      p0_occ = p0_occ + OCC_W'(p0_pipe[i]);
      p1_occ = p1_occ + OCC_W'(p1_pipe[i]);
    end
  end

  // A p0 write and a p1 read of the same word cannot share a macro cycle;
  // p0 wins and p1 retries next cycle, so it observes the written data.
  assign p1_collision = p0_req_valid && p0_req_we && (p0_req_addr == p1_req_addr);

  assign p0_req_ready = !reset && (p0_req_we || (p0_occ < CREDIT_LIMIT));
  assign p1_req_ready = !reset && !p1_collision && (p1_occ < CREDIT_LIMIT);

  assign p0_fire = p0_req_valid && p0_req_ready;
  assign p1_fire = p1_req_valid && p1_req_ready;

  // Decode what the accepted port-0 request does to the macro this cycle
  always_comb begin
    p0_kind = REQ_IDLE;
    if (p0_fire) begin
      if (!p0_req_we) begin
        p0_kind = REQ_READ;
      end else if (|p0_req_wmask) begin
        p0_kind = REQ_WRITE;
      end else begin
        p0_kind = REQ_WRITE_NOP;
      end
    end
  end

  assign p0_rd_fire = (p0_kind == REQ_READ);

  // Macro port-0 pins: one access per accepted read or non-empty write, idle otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      case (p0_kind)
        REQ_READ: begin
          sram_csb0  <= 1'b0;
          sram_addr0 <= p0_req_addr;
        end
        REQ_WRITE: begin
          sram_csb0   <= 1'b0;
          sram_web0   <= 1'b0;
          sram_wmask0 <= p0_req_wmask;
          sram_addr0  <= p0_req_addr;
          sram_din0   <= p0_req_wdata;
        end
        default: ;
      endcase
    end
  end

  // Macro port-1 pins: read-only, selected only on accepted requests
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
    end else begin
      sram_csb1 <= !p1_fire;
      if (p1_fire) begin
        sram_addr1 <= p1_req_addr;
      end
    end
  end

  // In-flight read markers; the oldest stage marks the edge where dout is sampled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p0_pipe <= '0;
      p1_pipe <= '0;
    end else begin
      p0_pipe <= {p0_pipe[LAT-2:0], p0_rd_fire};
      p1_pipe <= {p1_pipe[LAT-2:0], p1_fire};
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_p0_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (p0_pipe[LAT-1]),
    .push_data (sram_dout0),
    .pop       (p0_rsp_valid && p0_rsp_ready),
    .pop_data  (p0_rsp_rdata),
    .empty     (p0_fifo_empty),
    .count     (p0_count)
  );

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_p1_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (p1_pipe[LAT-1]),
    .push_data (sram_dout1),
    .pop       (p1_rsp_valid && p1_rsp_ready),
    .pop_data  (p1_rsp_rdata),
    .empty     (p1_fifo_empty),
    .count     (p1_count)
  );

  assign p0_rsp_valid = !p0_fifo_empty;
  assign p1_rsp_valid = !p1_fifo_empty;

endmodule
